// File: rtl/s1_scan_mux_if.sv
// Channel-select bus for s1_scan_mux: packed channel data and selection
// controls in, registered channel-tagged sample out.
interface s1_scan_mux_if #(
  parameter int SIZE = 5,
  parameter int CH   = 4
);
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH*SIZE-1:0] din;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic               en;
  logic [CH-1:0]      mask;
  logic [SIZE-1:0]    out;
  logic [SELW-1:0]    out_ch;
  logic               out_valid;

  // Producer side: drives channel data and selection controls.
  modport master (
    output din, sel, mode, en, mask,
    input  out, out_ch, out_valid
  );

  // Selector side: consumes the controls and presents the tagged sample.
  modport slave (
    input  din, sel, mode, en, mask,
    output out, out_ch, out_valid
  );
endinterface

// File: rtl/s1_scan_mux.sv
// s1_scan_mux: picks one of CH channels either by direct index or by
// round-robin scan over an enable mask, then carries the sample through a
// DEPTH-stage pipeline tagged with its source channel and a valid bit.
// Bubbles move the valid bit only; data/channel fields hold their last
// valid contents so out keeps showing the most recent sample.
module s1_scan_mux #(
  parameter int SIZE  = 5,
  parameter int CH    = 4,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          CLR,
  s1_scan_mux_if.slave bus
);
  localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

  // Constant-indexed mux so every slice base is static.
  function automatic logic [SIZE-1:0] pick(input logic [CH*SIZE-1:0] d,
                                           input logic [SELW-1:0]    idx);
    logic [SIZE-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      if (idx == SELW'(c)) begin
        r = d[c*SIZE +: SIZE];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_next;
  logic [SELW:0]   cand;
  logic            found;
  logic [SELW-1:0] k;
  logic            sel_ok;
  logic            cap_valid;
  logic [SELW-1:0] cap_ch;
  logic [SIZE-1:0] cap_data;

  logic [SIZE-1:0] data_q [DEPTH];
  logic [SELW-1:0] ch_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // The extra MSB on the compare keeps indices >= CH (non-power-of-two CH) out.
  assign sel_ok   = ({1'b0, bus.sel} < (SELW+1)'(CH));
  assign cap_data = pick(bus.din, cap_ch);

  // Find the first eligible channel at or after ptr, wrapping past CH-1.
  always_comb begin
    found = 1'b0;
    k     = '0;
    cand  = '0;
    for (int i = 0; i < CH; i++) begin
      cand = {1'b0, ptr} + (SELW+1)'(i);
      if (cand >= (SELW+1)'(CH)) begin
        cand = cand - (SELW+1)'(CH);
      end else begin
        cand = cand;
      end
      if (!found && bus.mask[cand[SELW-1:0]]) begin
        found = 1'b1;
        k     = cand[SELW-1:0];
      end else begin
        found = found;
      end
    end
  end

  // Decide what stage 1 captures this edge and where the scan pointer goes.
  always_comb begin
    cap_valid = 1'b0;
    cap_ch    = '0;
    ptr_next  = ptr;
    if (!bus.en) begin
      cap_valid = 1'b0;
    end else if (!bus.mode) begin
      cap_valid = sel_ok;
      cap_ch    = bus.sel;
    end else begin
      cap_valid = found;
      cap_ch    = k;
      if (found) begin
        ptr_next = (k == SELW'(CH - 1)) ? '0 : k + SELW'(1);
      end else begin
        ptr_next = ptr;
      end
    end
  end

  // Scan pointer plus the capture stage and the shifting pipeline.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      ptr     <= '0;
      valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
        ch_q[s]   <= '0;
      end
    end else begin
      ptr        <= ptr_next;
      valid_q[0] <= cap_valid;
      if (cap_valid) begin
        data_q[0] <= cap_data;
        ch_q[0]   <= cap_ch;
      end
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s] <= data_q[s-1];
          ch_q[s]   <= ch_q[s-1];
        end
      end
    end
  end

  assign bus.out       = data_q[DEPTH-1];
  assign bus.out_ch    = ch_q[DEPTH-1];
  assign bus.out_valid = valid_q[DEPTH-1];
endmodule

// File: tb/tb_s1_scan_mux.sv
// Bench for s1_scan_mux: a CH=4/DEPTH=2 and a CH=3/DEPTH=1 instance share
// stimulus; a per-edge capture history model predicts their outputs.
module tb_s1_scan_mux;
  logic clk = 1'b0;
  logic CLR;
  always #5 clk = ~clk;

  s1_scan_mux_if #(.SIZE(5), .CH(4)) if4 ();
  s1_scan_mux_if #(.SIZE(5), .CH(3)) if3 ();

  s1_scan_mux #(.SIZE(5), .CH(4), .DEPTH(2)) dut4 (.clk(clk), .CLR(CLR), .bus(if4.slave));
  s1_scan_mux #(.SIZE(5), .CH(3), .DEPTH(1)) dut3 (.clk(clk), .CLR(CLR), .bus(if3.slave));

  typedef struct { bit v; int d; int c; } ent_t;

  ent_t h4[$];
  ent_t h3[$];
  int   p4, p3;
  int   chans[4];
  int   errors = 0;
  int   checks = 0;
  logic [7:0] exp4, exp3;
  logic [7:0] obs4, obs3;

  assign obs4 = {if4.out_valid, if4.out_ch, if4.out};
  assign obs3 = {if3.out_valid, if3.out_ch, if3.out};

  // Stage-1 decision straight from the selection rules.
  function automatic void model_cap(input int n, input int ptr, input bit e, input bit m,
                                    input int s, input int msk,
                                    output bit v, output int c, output int np);
    v = 1'b0; c = 0; np = ptr;
    if (e && !m) begin
      if (s < n) begin v = 1'b1; c = s; end
    end else if (e && m) begin
      for (int i = 0; i < n; i++) begin
        int j;
        j = (ptr + i) % n;
        if (!v && ((msk >> j) & 1) == 1) begin
          v = 1'b1; c = j; np = (j + 1) % n;
        end
      end
    end
  endfunction

  // Output = valid of the capture DEPTH-1 edges ago, data/ch of the latest valid one up to then.
  function automatic logic [7:0] expect_out(input ent_t h[$], input int depth);
    int idx;
    logic [7:0] r;
    r = 8'h00;
    idx = h.size() - depth;
    if (idx >= 0) begin
      r[7] = h[idx].v;
      for (int j = idx; j >= 0; j--) begin
        if (h[j].v) begin
          r[6:0] = {2'(h[j].c), 5'(h[j].d)};
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    h4.delete(); h3.delete();
    p4 = 0; p3 = 0;
    exp4 = 8'h00; exp3 = 8'h00;
  endtask

  // Drive one cycle of stimulus, advance the models at the edge, sample #1 later.
  task automatic step(input bit e, input bit m, input int s, input int msk);
    bit v; int c, np;
    if4.en = e; if3.en = e;
    if4.mode = m; if3.mode = m;
    if4.sel = 2'(s); if3.sel = 2'(s);
    if4.mask = 4'(msk); if3.mask = 3'(msk);
    for (int i = 0; i < 4; i++) if4.din[i*5 +: 5] = 5'(chans[i]);
    for (int i = 0; i < 3; i++) if3.din[i*5 +: 5] = 5'(chans[i]);
    @(posedge clk);
    model_cap(4, p4, e, m, s, msk & 15, v, c, np);
    h4.push_back('{v: v, d: chans[c], c: c}); p4 = np;
    model_cap(3, p3, e, m, s, msk & 7, v, c, np);
    h3.push_back('{v: v, d: chans[c], c: c}); p3 = np;
    #1;
    exp4 = expect_out(h4, 2);
    exp3 = expect_out(h3, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    CLR = 1'b1;
    model_reset();
    @(negedge clk);
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs4 !== 8'h00) begin errors++; $display("FAIL reset_ch4: got %h expected %h", obs4, 8'h00); end
    checks++;
    if (obs3 !== 8'h00) begin errors++; $display("FAIL reset_ch3: got %h expected %h", obs3, 8'h00); end
    @(negedge clk);
    CLR = 1'b0;
  endtask

  task automatic test_direct();
    chans = '{3, 9, 17, 30};
    step(1'b1, 1'b0, 2, 0);
    checks++;
    if (obs4 !== 8'h00) begin errors++; $display("FAIL direct_lat1: got %h expected %h", obs4, 8'h00); end
    checks++;
    if (obs3 !== {1'b1, 2'd2, 5'd17}) begin errors++; $display("FAIL direct_d1: got %h expected %h", obs3, {1'b1, 2'd2, 5'd17}); end
    step(1'b0, 1'b0, 2, 0);
    checks++;
    if (obs4 !== {1'b1, 2'd2, 5'd17}) begin errors++; $display("FAIL direct_lat2: got %h expected %h", obs4, {1'b1, 2'd2, 5'd17}); end
    checks++;
    if (obs3 !== exp3) begin errors++; $display("FAIL direct_bubble_d1: got %h expected %h", obs3, exp3); end
  endtask

  task automatic test_scan();
    int sc[3] = '{0, 1, 3};
    logic [7:0] e;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 0, 4'b1011);
      checks++;
      if (obs4 !== exp4) begin errors++; $display("FAIL scan_model4 i=%0d: got %h expected %h", i, obs4, exp4); end
      checks++;
      if (obs3 !== exp3) begin errors++; $display("FAIL scan_model3 i=%0d: got %h expected %h", i, obs3, exp3); end
      if (i >= 1) begin
        e = {1'b1, 2'(sc[(i-1)%3]), 5'(chans[sc[(i-1)%3]])};
        checks++;
        if (obs4 !== e) begin errors++; $display("FAIL scan_seq i=%0d: got %h expected %h", i, obs4, e); end
      end
    end
  endtask

  task automatic test_bubbles();
    bit ens[3] = '{1'b1, 1'b0, 1'b1};
    int msks[4] = '{0, 0, 4'b0100, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      step(ens[i], 1'b1, 0, 4'b1011);
      checks++;
      if (obs4 !== exp4) begin errors++; $display("FAIL bubble4 i=%0d: got %h expected %h", i, obs4, exp4); end
      checks++;
      if (obs3 !== exp3) begin errors++; $display("FAIL bubble3 i=%0d: got %h expected %h", i, obs3, exp3); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 0, msks[i]);
      checks++;
      if (obs4 !== exp4) begin errors++; $display("FAIL emptymask4 i=%0d: got %h expected %h", i, obs4, exp4); end
      checks++;
      if (obs3 !== exp3) begin errors++; $display("FAIL emptymask3 i=%0d: got %h expected %h", i, obs3, exp3); end
    end
    checks++;
    if (obs4 !== {1'b1, 2'd2, 5'(chans[2])}) begin
      errors++; $display("FAIL mask_restore: got %h expected %h", obs4, {1'b1, 2'd2, 5'(chans[2])});
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    apply_reset();
    step(1'b1, 1'b0, 3, 0);
    checks++;
    if (obs3 !== 8'h00) begin errors++; $display("FAIL sel_oor3: got %h expected %h", obs3, 8'h00); end
    checks++;
    if (obs4 !== exp4) begin errors++; $display("FAIL sel3_on_ch4: got %h expected %h", obs4, exp4); end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 0, 4'b0111);
      e = {1'b1, 2'(i % 3), 5'(chans[i % 3])};
      checks++;
      if (obs3 !== e) begin errors++; $display("FAIL wrap3 i=%0d: got %h expected %h", i, obs3, e); end
      checks++;
      if (obs4 !== exp4) begin errors++; $display("FAIL wrap4 i=%0d: got %h expected %h", i, obs4, exp4); end
    end
  endtask

  task automatic test_mode_resume();
    apply_reset();
    chans = '{3, 9, 17, 30};
    repeat (2) step(1'b1, 1'b1, 0, 4'b1111);
    repeat (3) step(1'b1, 1'b0, 0, 4'b1111);
    step(1'b1, 1'b1, 0, 4'b1111);
    checks++;
    if (obs3 !== {1'b1, 2'd2, 5'd17}) begin errors++; $display("FAIL resume3: got %h expected %h", obs3, {1'b1, 2'd2, 5'd17}); end
    step(1'b1, 1'b1, 0, 4'b1111);
    checks++;
    if (obs4 !== {1'b1, 2'd2, 5'd17}) begin errors++; $display("FAIL resume4: got %h expected %h", obs4, {1'b1, 2'd2, 5'd17}); end
    checks++;
    if (obs4 !== exp4) begin errors++; $display("FAIL resume_model4: got %h expected %h", obs4, exp4); end
  endtask

  task automatic test_async_reset();
    repeat (3) step(1'b1, 1'b1, 0, 4'b1111);
    #2 CLR = 1'b1;
    #1;
    checks++;
    if (obs4 !== 8'h00) begin errors++; $display("FAIL async_clr4: got %h expected %h", obs4, 8'h00); end
    checks++;
    if (obs3 !== 8'h00) begin errors++; $display("FAIL async_clr3: got %h expected %h", obs3, 8'h00); end
    model_reset();
    #1 CLR = 1'b0;
    step(1'b1, 1'b1, 0, 4'b1111);
    checks++;
    if (obs3 !== {1'b1, 2'd0, 5'd3}) begin errors++; $display("FAIL post_clr3: got %h expected %h", obs3, {1'b1, 2'd0, 5'd3}); end
    checks++;
    if (obs4 !== 8'h00) begin errors++; $display("FAIL post_clr_empty4: got %h expected %h", obs4, 8'h00); end
    step(1'b1, 1'b1, 0, 4'b1111);
    checks++;
    if (obs4 !== {1'b1, 2'd0, 5'd3}) begin errors++; $display("FAIL post_clr4: got %h expected %h", obs4, {1'b1, 2'd0, 5'd3}); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < 4; c++) chans[c] = int'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) apply_reset();
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      checks++;
      if (obs4 !== exp4) begin errors++; $display("FAIL random4 i=%0d: got %h expected %h", i, obs4, exp4); end
      checks++;
      if (obs3 !== exp3) begin errors++; $display("FAIL random3 i=%0d: got %h expected %h", i, obs3, exp3); end
    end
  endtask

  initial begin
    if4.en = 1'b0; if4.mode = 1'b0; if4.sel = '0; if4.mask = '0; if4.din = '0;
    if3.en = 1'b0; if3.mode = 1'b0; if3.sel = '0; if3.mask = '0; if3.din = '0;
    chans = '{3, 9, 17, 30};
    test_reset();
    test_direct();
    test_scan();
    test_bubbles();
    test_wrap();
    test_mode_resume();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
